// File: rtl/div_if.sv
// Handshake bundle between the EX stage and the iterative divider.
// The EX side drives the request and the flush; the divider answers.
interface div_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            flush;
    logic            stall_req;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, dividend, divisor, flush,
        input  stall_req, done, result
    );

    modport slave (
        input  start, op, dividend, divisor, flush,
        output stall_req, done, result
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Stalls the pipeline while busy; result pulses with done.
module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic clk,
    input  logic rst_n,
    div_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [XLEN:0]    r_acc;
    logic [XLEN-1:0]  r_quot;
    logic [XLEN-1:0]  r_dvsr;
    logic [XLEN-1:0]  r_result;

    logic            w_signed;
    logic            w_is_rem;
    logic            w_sa;
    logic            w_sb;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_spec;

    assign w_signed = ~bus.op[0];
    assign w_is_rem = bus.op[1];
    assign w_sa     = w_signed & bus.dividend[XLEN-1];
    assign w_sb     = w_signed & bus.divisor[XLEN-1];
    assign w_abs_a  = w_sa ? -bus.dividend : bus.dividend;
    assign w_abs_b  = w_sb ? -bus.divisor : bus.divisor;
    assign w_div0   = (bus.divisor == '0);
    assign w_ovf    = w_signed
                    & (bus.dividend == {1'b1, {(XLEN-1){1'b0}}})
                    & (bus.divisor == '1);

    // Divide-by-zero and overflow results as fixed by the ISA
    always_comb begin
        w_spec = '0;
        if (w_div0)
            w_spec = w_is_rem ? bus.dividend : '1;
        else if (w_ovf)
            w_spec = w_is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_sub;
    logic            w_ge;
    logic [XLEN:0]   w_acc_n;
    logic [XLEN-1:0] w_quot_n;
    logic [XLEN-1:0] w_rem_f;
    logic [XLEN-1:0] w_quo_f;
    logic            w_last;

    assign w_shift  = {r_acc[XLEN-1:0], r_quot[XLEN-1]};
    assign w_sub    = w_shift - {1'b0, r_dvsr};
    assign w_ge     = ~w_sub[XLEN];
    assign w_acc_n  = w_ge ? w_sub : w_shift;
    assign w_quot_n = {r_quot[XLEN-2:0], w_ge};
    assign w_rem_f  = r_neg_r ? -w_acc_n[XLEN-1:0]
                              : w_acc_n[XLEN-1:0];
    assign w_quo_f  = r_neg_q ? -w_quot_n : w_quot_n;
    assign w_last   = (r_cnt == CNT_W'(XLEN-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_acc    <= '0;
            r_quot   <= '0;
            r_dvsr   <= '0;
            r_result <= '0;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_is_rem <= w_is_rem;
                        r_neg_q  <= w_sa ^ w_sb;
                        r_neg_r  <= w_sa;
                        r_quot   <= w_abs_a;
                        r_dvsr   <= w_abs_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        if (w_div0 || w_ovf) begin
                            r_result <= w_spec;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    r_acc  <= w_acc_n;
                    r_quot <= w_quot_n;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= r_is_rem ? w_rem_f : w_quo_f;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.stall_req = ((r_state == S_IDLE) & bus.start & ~bus.flush)
                         | (r_state == S_BUSY);
    assign bus.done      = (r_state == S_DONE);
    assign bus.result    = r_result;
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 integer divider in the EX stage. Executes RV32M DIV/DIVU/REM/REMU.
- Acts as the initiator of stall requests into the pipeline hazard logic. It holds stall_req high while a division is in flight.
- It obeys the flush issued by hazard logic and abandons the operation.
- Result is presented for one cycle with done, so EX can forward it down the pipeline.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  EX holds a divide op; sampled only in IDLE
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend  input  XLEN  rs1 value (post-forwarding)
- divisor  input  XLEN  rs2 value (post-forwarding)
- flush  input  1  abort current op (EX flush from hazard logic)
- stall_req  output  1  request to stall PC, IF/ID, ID/EX and EX/MEM
- done  output  1  result valid, one cycle
- result  output  XLEN  quotient or remainder per latched op

Behaviour:
- Reset (rst_n=0, async): state=IDLE, counter=0, all internal regs=0. Outputs: stall_req=0, done=0, result=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE: start=1 and flush=0 at an edge latches op, the signs and |operands|.
  - Divisor==0 or signed overflow: next state DONE.
  - Otherwise: remainder acc=0, count=0, next state BUSY.
- BUSY: each edge does one shift-subtract step.
  - Shift {acc,quot} left 1. If acc>=|divisor|, subtract and set quot LSB=1.
  - count increments. After XLEN steps (count==XLEN-1 at the edge) the next state is DONE.
  - Sign fix-up is applied when loading result: quotient negated if sign(dividend)^sign(divisor) for DIV; remainder negated if sign(dividend) for REM; unsigned ops have no fix-up.
- DONE: lasts exactly one cycle, then IDLE. result is registered and stable in DONE; result holds its value afterwards until the next DONE.
- stall_req (combinational) = (IDLE & start & ~flush) | BUSY.
  - Low in DONE, so the pipeline advances and consumes result in that cycle.
- done (combinational) = DONE state.
- Latency, normal case: start cycle C0, BUSY C1..C32, DONE C33 (XLEN+1 cycles after C0). stall_req is high C0..C32.
- Special cases (RISC-V spec), 1-cycle path with DONE at C1:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU result = dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, REM = 0.
- Unsigned ops never take the overflow path.
- Inputs in BUSY/DONE: start and operand changes are ignored; operands are latched only in IDLE.
- Flush takes priority over everything.
  - flush=1 at an edge in any state: next state IDLE; DONE is never entered for the aborted op; result is not updated.
  - While flush=1, stall_req = BUSY only. The IDLE term is gated off, so a flushed start never stalls.
- Start arriving in the DONE cycle is not accepted; it is accepted in the following IDLE cycle. EX re-presents the op because stall_req was low only for the completing instruction.
- Async reset asserted mid-operation: immediate return to IDLE with all outputs 0.
- All arithmetic is XLEN bits. acc is XLEN+1 bits internally to hold the compare/subtract borrow.

Test Plan:
- DIVU 100 / 7 -> stall_req high 33 cycles (C0..C32); done in C33 with result=14. Repeat with REMU -> result=2.
- DIV -20 (0xFFFFFFEC) / 3 -> result 0xFFFFFFFA (-6). REM same operands -> 0xFFFFFFFE (-2). REM 20 / -3 -> 2.
- DIVU 5 / 0 -> done at C1, result=0xFFFFFFFF, stall_req high only in C0. REM 5 / 0 -> result=5.
- DIV 0x80000000 / 0xFFFFFFFF -> done at C1, result=0x80000000. REM same operands -> 0.
- Start DIVU 1000/10, assert flush at C10 -> IDLE at C11, stall_req=0, done never asserted, result unchanged. New start in C12 completes normally with result=100.
- Drop rst_n at C15 of a divide -> stall_req=0, done=0, result=0 immediately. After release, a start with DIVU 9/3 -> result=3 at C33.
